// File: rtl/tile_sched_pkg.sv
// Shared types and geometry helpers for the tile scheduler.
// Imported by tile_coord_counter and tile_scheduler.
package tile_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_STORE,
        ST_DONE
    } tile_sched_state_e;

    function automatic int calc_tiles(input int img, input int tile);
        return img / tile;
    endfunction

    // A single-tile axis still needs a 1-bit coordinate port.
    function automatic int calc_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tile_coord_counter.sv
// 2-D raster wrap counter for tile coordinates: clear resets to (0,0), advance
// steps x and carries into y; last flags the bottom-right tile.
module tile_coord_counter
    import tile_sched_pkg::*;
#(
    parameter int NTX = 4,
    parameter int NTY = 4,
    parameter int TXW = 2,
    parameter int TYW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear_i,
    input  logic           advance_i,
    output logic [TXW-1:0] tile_x_o,
    output logic [TYW-1:0] tile_y_o,
    output logic           last_o
);

    localparam logic [TXW-1:0] XMAX = TXW'(NTX - 1);
    localparam logic [TYW-1:0] YMAX = TYW'(NTY - 1);

    logic [TXW-1:0] x_q, x_d;
    logic [TYW-1:0] y_q, y_d;
    logic           x_last, y_last;

    assign x_last = (x_q == XMAX);
    assign y_last = (y_q == YMAX);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + TYW'(1);
            end else begin
                x_d = x_q + TXW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign tile_x_o = x_q;
    assign tile_y_o = y_q;
    assign last_o   = x_last && y_last;

endmodule

// File: rtl/tile_scheduler.sv
// Frame-level tile sequencer: raster walk of tiles with load/compute/store handshakes.
// Define TILE_SCHED_DBUF_EN to make buf_sel ping-pong per tile; otherwise it stays 0.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int TILE_W = 16,
    parameter int TILE_H = 16,
    localparam int NTX = calc_tiles(IMG_W, TILE_W),
    localparam int NTY = calc_tiles(IMG_H, TILE_H),
    localparam int TXW = calc_width(NTX),
    localparam int TYW = calc_width(NTY)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           dma_start,
    input  logic           dma_done,
    output logic           compute_start,
    input  logic           compute_done,
    output logic           store_start,
    input  logic           store_done,
    output logic [TXW-1:0] tile_x,
    output logic [TYW-1:0] tile_y,
    output logic           buf_sel,
    output logic           frame_done
);

    if (((IMG_W % TILE_W) != 0) || ((IMG_H % TILE_H) != 0)) begin : g_bad_geometry
        $error("tile_scheduler: IMG_W/IMG_H must be multiples of TILE_W/TILE_H");
    end

    tile_sched_state_e state_q, state_d;
    logic dma_start_q, dma_start_d;
    logic compute_start_q, compute_start_d;
    logic store_start_q, store_start_d;
    logic frame_done_q, frame_done_d;
    logic buf_sel_q, buf_sel_d;
    logic coord_clear, coord_advance, coord_last;

    tile_coord_counter #(
        .NTX(NTX),
        .NTY(NTY),
        .TXW(TXW),
        .TYW(TYW)
    ) u_coord (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (coord_clear),
        .advance_i(coord_advance),
        .tile_x_o (tile_x),
        .tile_y_o (tile_y),
        .last_o   (coord_last)
    );

    // A done coincident with its own start pulse belongs to a previous request and is dropped.
    always_comb begin
        state_d         = state_q;
        dma_start_d     = 1'b0;
        compute_start_d = 1'b0;
        store_start_d   = 1'b0;
        frame_done_d    = 1'b0;
        buf_sel_d       = buf_sel_q;
        coord_clear     = 1'b0;
        coord_advance   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    coord_clear = 1'b1;
                    buf_sel_d   = 1'b0;
                    dma_start_d = 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (dma_done && !dma_start_q) begin
                    compute_start_d = 1'b1;
                    state_d         = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (compute_done && !compute_start_q) begin
                    store_start_d = 1'b1;
                    state_d       = ST_STORE;
                end
            end
            ST_STORE: begin
                if (store_done && !store_start_q) begin
                    if (coord_last) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        coord_advance = 1'b1;
`ifdef TILE_SCHED_DBUF_EN
                        buf_sel_d = ~buf_sel_q;
`else
                        buf_sel_d = 1'b0;
`endif
                        dma_start_d = 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            dma_start_q     <= 1'b0;
            compute_start_q <= 1'b0;
            store_start_q   <= 1'b0;
            frame_done_q    <= 1'b0;
            buf_sel_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            dma_start_q     <= dma_start_d;
            compute_start_q <= compute_start_d;
            store_start_q   <= store_start_d;
            frame_done_q    <= frame_done_d;
            buf_sel_q       <= buf_sel_d;
        end
    end

    assign dma_start     = dma_start_q;
    assign compute_start = compute_start_q;
    assign store_start   = store_start_q;
    assign frame_done    = frame_done_q;
    assign buf_sel       = buf_sel_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: a 4x4-tile frame (DUT A) and a 2x1-tile frame (DUT B),
// with a handshake vector table, randomized engine latencies, junk injection and mid-frame reset.
module tb_tile_scheduler;

`ifdef TILE_SCHED_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic startI [2];
    logic dmaDoneI [2];
    logic compDoneI [2];
    logic storeDoneI [2];

    logic       dmaA, compA, storeA, fdA, bufA;
    logic [1:0] txA, tyA;
    logic       dmaB, compB, storeB, fdB, bufB;
    logic [0:0] txB, tyB;

    int sel = 0;
    logic obsDma, obsComp, obsStore, obsFd, obsBuf;
    int   obsTx, obsTy;

    int checks = 0;
    int errors = 0;
    int dmaCntA = 0, fdCntA = 0, dmaCntB = 0, fdCntB = 0;

    typedef struct {
        bit start, dmaDone, compDone, storeDone;
        bit eDma, eComp, eStore, eFd;
        int ex, ey, eBuf;
    } vec_t;

    vec_t tbl [12];

    tile_scheduler dutA (
        .clk(clk), .rst_n(rst_n), .start(startI[0]),
        .dma_start(dmaA), .dma_done(dmaDoneI[0]),
        .compute_start(compA), .compute_done(compDoneI[0]),
        .store_start(storeA), .store_done(storeDoneI[0]),
        .tile_x(txA), .tile_y(tyA), .buf_sel(bufA), .frame_done(fdA)
    );

    tile_scheduler #(.IMG_W(32), .IMG_H(16), .TILE_W(16), .TILE_H(16)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startI[1]),
        .dma_start(dmaB), .dma_done(dmaDoneI[1]),
        .compute_start(compB), .compute_done(compDoneI[1]),
        .store_start(storeB), .store_done(storeDoneI[1]),
        .tile_x(txB), .tile_y(tyB), .buf_sel(bufB), .frame_done(fdB)
    );

    always #5 clk = ~clk;

    always_comb begin
        obsDma   = (sel == 0) ? dmaA   : dmaB;
        obsComp  = (sel == 0) ? compA  : compB;
        obsStore = (sel == 0) ? storeA : storeB;
        obsFd    = (sel == 0) ? fdA    : fdB;
        obsBuf   = (sel == 0) ? bufA   : bufB;
        obsTx    = (sel == 0) ? int'(txA) : int'(txB);
        obsTy    = (sel == 0) ? int'(tyA) : int'(tyB);
    end

    always @(posedge clk) begin
        if (dmaA) dmaCntA++;
        if (fdA)  fdCntA++;
        if (dmaB) dmaCntB++;
        if (fdB)  fdCntB++;
    end

    function automatic int expBuf(input int k);
        return DBUF ? (k % 2) : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expectOuts(input string tag, input bit d, input bit c, input bit s, input bit f,
                              input int ex, input int ey, input int eb);
        checkOutput({tag, ".dma_start"},     int'(obsDma),   int'(d));
        checkOutput({tag, ".compute_start"}, int'(obsComp),  int'(c));
        checkOutput({tag, ".store_start"},   int'(obsStore), int'(s));
        checkOutput({tag, ".frame_done"},    int'(obsFd),    int'(f));
        checkOutput({tag, ".tile_x"},        obsTx,          ex);
        checkOutput({tag, ".tile_y"},        obsTy,          ey);
        checkOutput({tag, ".buf_sel"},       int'(obsBuf),   eb);
    endtask

    task automatic waitQuiet(input string tag, input int n, input int ex, input int ey, input int eb);
        for (int i = 0; i < n; i++) begin
            step();
            expectOuts(tag, 0, 0, 0, 0, ex, ey, eb);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        startI[0]     = v.start;
        dmaDoneI[0]   = v.dmaDone;
        compDoneI[0]  = v.compDone;
        storeDoneI[0] = v.storeDone;
        step();
        startI[0]     = 1'b0;
        dmaDoneI[0]   = 1'b0;
        compDoneI[0]  = 1'b0;
        storeDoneI[0] = 1'b0;
    endtask

    // Reference: tile k of a frame sits at (k % ntx, k / ntx) with buffer k % 2 when ping-pong is on.
    task automatic runFrame(input int s, input int ntx, input int nty, input int abortTile, input bit junk);
        int ntiles;
        int ex, ey, eb;
        ntiles = ntx * nty;
        sel = s;
        startI[s] = 1'b1;
        step();
        startI[s] = 1'b0;
        expectOuts("go", 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < ntiles; k++) begin
            ex = k % ntx;
            ey = k / ntx;
            eb = expBuf(k);
            if (junk && k == 2) begin
                dmaDoneI[s] = 1'b1;
                step();
                dmaDoneI[s] = 1'b0;
                expectOuts("samecycle", 0, 0, 0, 0, ex, ey, eb);
            end
            if (junk && k == 5) begin
                startI[s] = 1'b1;
                compDoneI[s] = 1'b1;
                storeDoneI[s] = 1'b1;
                step();
                startI[s] = 1'b0;
                compDoneI[s] = 1'b0;
                storeDoneI[s] = 1'b0;
                expectOuts("junk", 0, 0, 0, 0, ex, ey, eb);
            end
            waitQuiet("load.wait", $urandom_range(1, 20), ex, ey, eb);
            dmaDoneI[s] = 1'b1;
            step();
            dmaDoneI[s] = 1'b0;
            expectOuts("load.done", 0, 1, 0, 0, ex, ey, eb);
            if (k == abortTile) begin
                waitQuiet("comp.wait", 2, ex, ey, eb);
                #2 rst_n = 1'b0;
                #1 expectOuts("abort", 0, 0, 0, 0, 0, 0, 0);
                compDoneI[s] = 1'b1;
                waitQuiet("abort.hold", 3, 0, 0, 0);
                compDoneI[s] = 1'b0;
                rst_n = 1'b1;
                waitQuiet("abort.after", 3, 0, 0, 0);
                return;
            end
            waitQuiet("comp.wait", $urandom_range(1, 20), ex, ey, eb);
            compDoneI[s] = 1'b1;
            step();
            compDoneI[s] = 1'b0;
            expectOuts("comp.done", 0, 0, 1, 0, ex, ey, eb);
            waitQuiet("store.wait", $urandom_range(1, 20), ex, ey, eb);
            storeDoneI[s] = 1'b1;
            step();
            storeDoneI[s] = 1'b0;
            if (k == ntiles - 1)
                expectOuts("last", 0, 0, 0, 1, ex, ey, eb);
            else
                expectOuts("advance", 1, 0, 0, 0, (k + 1) % ntx, (k + 1) / ntx, expBuf(k + 1));
        end
        waitQuiet("hold", 3, ntx - 1, nty - 1, expBuf(ntiles - 1));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            startI[i] = 1'b0;
            dmaDoneI[i] = 1'b0;
            compDoneI[i] = 1'b0;
            storeDoneI[i] = 1'b0;
        end
        //           start dd cd sd  eD eC eS eF  ex ey eb
        tbl[0]  = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[3]  = '{0, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0,  0, 1, 0, 0,  0, 0, 0};
        tbl[6]  = '{0, 1, 1, 1,  0, 0, 0, 0,  0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0,  0, 0, 1, 0,  0, 0, 0};
        tbl[8]  = '{0, 1, 0, 1,  0, 0, 0, 0,  0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1,  1, 0, 0, 0,  1, 0, 1};
        tbl[10] = '{0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1};
        tbl[11] = '{0, 0, 1, 0,  0, 0, 0, 0,  1, 0, 1};

        #2;
        sel = 0;
        #1 expectOuts("resetA", 0, 0, 0, 0, 0, 0, 0);
        sel = 1;
        #1 expectOuts("resetB", 0, 0, 0, 0, 0, 0, 0);
        sel = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        expectOuts("idle", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i]);
            expectOuts($sformatf("vec%0d", i), tbl[i].eDma, tbl[i].eComp, tbl[i].eStore, tbl[i].eFd,
                       tbl[i].ex, tbl[i].ey, DBUF ? tbl[i].eBuf : 0);
        end

        #2 rst_n = 1'b0;
        #1 expectOuts("vecReset", 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();

        runFrame(0, 4, 4, -1, 1'b1);
        runFrame(0, 4, 4, 7, 1'b0);
        runFrame(0, 4, 4, -1, 1'b0);
        runFrame(1, 2, 1, -1, 1'b0);

        step();
        checkOutput("dmaCountA", dmaCntA, 42);
        checkOutput("frameDoneCountA", fdCntA, 2);
        checkOutput("dmaCountB", dmaCntB, 2);
        checkOutput("frameDoneCountB", fdCntB, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
